// File: rtl/kbd_scan_pkg.sv
// Shared constants for the scan-code encoder: set-2 make codes per key,
// break prefix and the encoder FSM state type.
package kbd_scan_pkg;

  localparam logic [7:0] CODE_DO_1    = 8'h16;
  localparam logic [7:0] CODE_RE      = 8'h1E;
  localparam logic [7:0] CODE_MI      = 8'h26;
  localparam logic [7:0] CODE_FA      = 8'h25;
  localparam logic [7:0] CODE_SOL     = 8'h2E;
  localparam logic [7:0] CODE_LA      = 8'h36;
  localparam logic [7:0] CODE_SI      = 8'h3D;
  localparam logic [7:0] CODE_DO_2    = 8'h3E;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_F0,
    ST_SEND_CODE,
    ST_GAP
  } state_t;

endpackage

// File: rtl/kbd_code_lut.sv
// Key index to set-2 make code; purely combinational so the key tracker
// can share the same table.
module kbd_code_lut
  import kbd_scan_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] code
);

  always_comb begin
    case (idx)
      3'd0:    code = CODE_DO_1;
      3'd1:    code = CODE_RE;
      3'd2:    code = CODE_MI;
      3'd3:    code = CODE_FA;
      3'd4:    code = CODE_SOL;
      3'd5:    code = CODE_LA;
      3'd6:    code = CODE_SI;
      default: code = CODE_DO_2;
    endcase
  end

endmodule

// File: rtl/kbd_scan_encoder.sv
// Converts a held-key bitmap into a make / F0+code byte stream on a
// valid/ready interface, one key event at a time, lowest key first.
module kbd_scan_encoder
  import kbd_scan_pkg::*;
#(
  parameter int BYTE_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_state,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pending
);

  localparam int GAP_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;

  state_t             state_q, state_d;
  state_t             after_gap_q, after_gap_d;
  logic [7:0]         sent_q, sent_d;
  logic [2:0]         idx_q, idx_d;
  logic               dir_q, dir_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [7:0] diff;
  logic [2:0] pick_idx;
  logic [2:0] lut_idx;
  logic [7:0] code;
  logic       accept;

  assign diff    = key_state ^ sent_q;
  assign accept  = valid_q && out_ready;
  assign pending = (state_q != ST_IDLE) || (|diff);

  // Descending scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    pick_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (diff[i]) pick_idx = 3'(i);
    end
  end

  // In IDLE the code is for the key being picked; afterwards for the latched one.
  assign lut_idx = (state_q == ST_IDLE) ? pick_idx : idx_q;

  kbd_code_lut u_code_lut (
    .idx  (lut_idx),
    .code (code)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d     = state_q;
    after_gap_d = after_gap_q;
    sent_d      = sent_q;
    idx_d       = idx_q;
    dir_d       = dir_q;
    data_d      = data_q;
    valid_d     = valid_q;
    gap_d       = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (|diff) begin
          idx_d   = pick_idx;
          dir_d   = key_state[pick_idx];
          valid_d = 1'b1;
          if (key_state[pick_idx]) begin
            data_d  = code;
            state_d = ST_SEND_CODE;
          end else begin
            data_d  = BREAK_PREFIX;
            state_d = ST_SEND_F0;
          end
        end
      end

      ST_SEND_F0: begin
        if (accept) begin
          if (BYTE_GAP == 0) begin
            data_d  = code;
            state_d = ST_SEND_CODE;
          end else begin
            valid_d     = 1'b0;
            gap_d       = '0;
            after_gap_d = ST_SEND_CODE;
            state_d     = ST_GAP;
          end
        end
      end

      ST_SEND_CODE: begin
        if (accept) begin
          sent_d[idx_q] = dir_q;
          valid_d       = 1'b0;
          if (BYTE_GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d       = '0;
            after_gap_d = ST_IDLE;
            state_d     = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_W'(BYTE_GAP - 1)) begin
          state_d = after_gap_q;
          if (after_gap_q == ST_SEND_CODE) begin
            data_d  = code;
            valid_d = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all decisions live in the always_comb above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      after_gap_q <= ST_IDLE;
      sent_q      <= '0;
      idx_q       <= '0;
      dir_q       <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      after_gap_q <= after_gap_d;
      sent_q      <= sent_d;
      idx_q       <= idx_d;
      dir_q       <= dir_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      gap_q       <= gap_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule
